// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder: valid/ready load/store channel, sized little-endian access.
// Optional macro DMEM_RESET_CLEAR_EN zeroes the doubleword array on reset.
module data_memory_responder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 48
) (
    input  logic              clockInput,
    input  logic              resetInput,
    input  logic              requestValid,
    output logic              requestReady,
    input  logic              requestWrite,
    input  logic [ADDR_W-1:0] requestAddress,
    input  logic [1:0]        requestSize,
    input  logic              requestUnsigned,
    input  logic [63:0]       requestWriteData,
    output logic              responseValid,
    input  logic              responseReady,
    output logic [63:0]       responseReadData,
    output logic              responseError
);

    localparam int unsigned     IdxW     = $clog2(DEPTH);
    localparam logic [ADDR_W:0] MemBytes = (ADDR_W + 1)'(DEPTH * 8);

    typedef enum logic [1:0] {StIdle, StWait, StRespond} state_e;

    state_e              state_q, state_d;
    logic [3:0]          count_q, count_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [63:0]         wdata_q, wdata_d;
    logic [63:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [63:0]         mem_q [DEPTH];

    logic                do_access;
    logic                acc_wr, acc_uns, acc_err, misaligned, out_of_range;
    logic [ADDR_W-1:0]   acc_addr;
    logic [1:0]          acc_size;
    logic [63:0]         acc_wdata;
    logic [2:0]          acc_off;
    logic [IdxW-1:0]     acc_idx;
    logic [63:0]         old_word, shifted, load_data, bit_mask, new_word;
    logic [7:0]          lane_mask, byte_mask;
    logic                mem_we;

    // With zero latency the access happens on the accept edge, so use the live request.
    always_comb begin
        if (state_q == StIdle) begin
            acc_wr    = requestWrite;
            acc_addr  = requestAddress;
            acc_size  = requestSize;
            acc_uns   = requestUnsigned;
            acc_wdata = requestWriteData;
        end else begin
            acc_wr    = wr_q;
            acc_addr  = addr_q;
            acc_size  = size_q;
            acc_uns   = uns_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        acc_off      = acc_addr[2:0];
        acc_idx      = acc_addr[IdxW+2:3];
        out_of_range = ({1'b0, acc_addr} >= MemBytes);
        misaligned   = 1'b0;
        lane_mask    = 8'h00;
        unique case (acc_size)
            2'd0: begin misaligned = 1'b0;          lane_mask = 8'h01; end
            2'd1: begin misaligned = acc_off[0];    lane_mask = 8'h03; end
            2'd2: begin misaligned = |acc_off[1:0]; lane_mask = 8'h0F; end
            default: begin misaligned = |acc_off;   lane_mask = 8'hFF; end
        endcase
        acc_err  = misaligned | out_of_range;
        old_word = mem_q[acc_idx];
        shifted  = old_word >> {acc_off, 3'b000};

        load_data = shifted;
        unique case (acc_size)
            2'd0: load_data = acc_uns ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
            2'd1: load_data = acc_uns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'd2: load_data = acc_uns ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase

        byte_mask = lane_mask << acc_off;
        bit_mask  = '0;
        for (int b = 0; b < 8; b++) begin
            bit_mask[8*b +: 8] = {8{byte_mask[b]}};
        end
        new_word = (old_word & ~bit_mask) | ((acc_wdata << {acc_off, 3'b000}) & bit_mask);
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        size_d    = size_q;
        uns_d     = uns_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (requestValid) begin
                    wr_d    = requestWrite;
                    addr_d  = requestAddress;
                    size_d  = requestSize;
                    uns_d   = requestUnsigned;
                    wdata_d = requestWriteData;
                    if (LATENCY == 0) begin
                        do_access = 1'b1;
                        state_d   = StRespond;
                    end else begin
                        count_d = 4'(LATENCY - 1);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (count_q == 4'd0) begin
                    do_access = 1'b1;
                    state_d   = StRespond;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            StRespond: begin
                if (responseReady) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (do_access) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_wr) ? 64'd0 : load_data;
        end
    end

    // A store whose commit edge sees reset is dropped.
    assign mem_we = do_access & acc_wr & ~acc_err & ~resetInput;

    always_ff @(posedge clockInput) begin
        if (resetInput) begin
            state_q <= StIdle;
            count_q <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clockInput) begin
`ifdef DMEM_RESET_CLEAR_EN
        if (resetInput) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 64'd0;
            end
        end else
`endif
        if (mem_we) begin
            mem_q[acc_idx] <= new_word;
        end
    end

    assign requestReady     = (state_q == StIdle);
    assign responseValid    = (state_q == StRespond);
    assign responseReadData = rdata_q;
    assign responseError    = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed vector table plus
// backpressure and reset-during-wait sequences.
module tb_data_memory_responder;

    localparam int unsigned Latency = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_uns;
    logic [47:0] req_addr;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_memory_responder #(
        .DEPTH  (64),
        .LATENCY(Latency),
        .ADDR_W (48)
    ) dut (
        .clockInput      (clk),
        .resetInput      (rst),
        .requestValid    (req_valid),
        .requestReady    (req_ready),
        .requestWrite    (req_write),
        .requestAddress  (req_addr),
        .requestSize     (req_size),
        .requestUnsigned (req_uns),
        .requestWriteData(req_wdata),
        .responseValid   (rsp_valid),
        .responseReady   (rsp_ready),
        .responseReadData(rsp_data),
        .responseError   (rsp_err)
    );

    typedef struct {
        logic        wr;
        logic [47:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] wdata;
        logic [63:0] exp_data;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic wr, input logic [47:0] addr, input logic [1:0] size,
                                input logic uns, input logic [63:0] wdata,
                                input logic [63:0] exp_data, input logic exp_err,
                                input string name);
        vec_t v;
        v.wr = wr; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
        v.exp_data = exp_data; v.exp_err = exp_err; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a falling edge with the DUT idle.
    task automatic do_req(input logic wr, input logic [47:0] addr, input logic [1:0] size,
                          input logic uns, input logic [63:0] wdata,
                          input logic [63:0] exp_data, input logic exp_err, input string name);
        int n;
        chk({name, " req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_size = size; req_uns = uns; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'(Latency + 1));
        chk({name, " data"}, rsp_data, exp_data);
        chk({name, " err"}, 64'(rsp_err), 64'(exp_err));
        if (rsp_ready) begin
            @(negedge clk);
            chk({name, " ready after handshake"}, 64'(req_ready), 64'd1);
            chk({name, " valid after handshake"}, 64'(rsp_valid), 64'd0);
        end
    endtask

    logic [63:0] prior18;
    logic [63:0] hold_data;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = 2'd0;
        req_uns = 1'b0; req_wdata = '0; rsp_ready = 1'b1;

        add(1, 48'h10, 2'd3, 0, 64'h1122334455667788, 64'h0, 0, "sd 0x10");
        add(0, 48'h10, 2'd3, 0, 64'h0, 64'h1122334455667788, 0, "ld 0x10");
        add(0, 48'h17, 2'd0, 0, 64'h0, 64'h0000000000000011, 0, "lb 0x17");
        add(0, 48'h10, 2'd0, 0, 64'h0, 64'hFFFFFFFFFFFFFF88, 0, "lb 0x10");
        add(0, 48'h10, 2'd0, 1, 64'h0, 64'h0000000000000088, 0, "lbu 0x10");
        add(0, 48'h12, 2'd1, 0, 64'h0, 64'h0000000000005566, 0, "lh 0x12");
        add(1, 48'h13, 2'd0, 0, 64'hFFFFFFFFFFFFFFAB, 64'h0, 0, "sb 0x13");
        add(0, 48'h10, 2'd3, 0, 64'h0, 64'h11223344AB667788, 0, "ld after sb");
        add(0, 48'h12, 2'd2, 0, 64'h0, 64'h0, 1, "lw misaligned");
        add(1, 48'h200, 2'd3, 0, 64'hDEADDEADDEADDEAD, 64'h0, 1, "sd out of range");
        add(0, 48'h10, 2'd3, 0, 64'h0, 64'h11223344AB667788, 0, "ld after bad sd");
        add(1, 48'h14, 2'd1, 0, 64'h1234000000008001, 64'h0, 0, "sh 0x14");
        add(0, 48'h14, 2'd1, 0, 64'h0, 64'hFFFFFFFFFFFF8001, 0, "lh 0x14");
        add(0, 48'h14, 2'd2, 0, 64'h0, 64'h0000000011228001, 0, "lw 0x14");
        add(0, 48'h16, 2'd1, 1, 64'h0, 64'h0000000000001122, 0, "lhu 0x16");
        add(1, 48'h18, 2'd2, 0, 64'hAAAAAAAA87654321, 64'h0, 0, "sw 0x18");
        add(0, 48'h18, 2'd2, 0, 64'h0, 64'hFFFFFFFF87654321, 0, "lw 0x18");
        add(0, 48'h18, 2'd2, 1, 64'h0, 64'h0000000087654321, 0, "lwu 0x18");
        add(0, 48'h11, 2'd1, 0, 64'h0, 64'h0, 1, "lh misaligned");
        add(1, 48'h14, 2'd3, 0, 64'h5555555555555555, 64'h0, 1, "sd misaligned");
        add(1, 48'h1F8, 2'd3, 0, 64'hDEADBEEFCAFEF00D, 64'h0, 0, "sd last dword");
        add(0, 48'h1F8, 2'd3, 1, 64'h0, 64'hDEADBEEFCAFEF00D, 0, "ld last dword");
        add(0, 48'h10, 2'd3, 0, 64'h0, 64'h11228001AB667788, 0, "ld 0x10 final");

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset req_ready", 64'(req_ready), 64'd1);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset rsp_data", rsp_data, 64'd0);
        chk("reset rsp_err", 64'(rsp_err), 64'd0);

        foreach (vecs[i]) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                   vecs[i].exp_data, vecs[i].exp_err, vecs[i].name);
        end

        // Backpressure: response held while a competing request is offered.
        rsp_ready = 1'b0;
        do_req(0, 48'h10, 2'd3, 0, 64'h0, 64'h11228001AB667788, 0, "bp ld");
        hold_data = 64'h11228001AB667788;
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 48'h10; req_size = 2'd3;
            req_wdata = 64'h0;
            @(negedge clk);
            chk("bp rsp_valid held", 64'(rsp_valid), 64'd1);
            chk("bp rsp_data held", rsp_data, hold_data);
            chk("bp rsp_err held", 64'(rsp_err), 64'd0);
            chk("bp req_ready low", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0; req_write = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp ready after release", 64'(req_ready), 64'd1);
        chk("bp valid after release", 64'(rsp_valid), 64'd0);
        do_req(0, 48'h10, 2'd3, 0, 64'h0, 64'h11228001AB667788, 0, "ld after ignored sd");

        // Reset coinciding with the commit edge of a store.
        do_req(1, 48'h18, 2'd3, 0, 64'h0123456789ABCDEF, 64'h0, 0, "sd 0x18 prior");
        req_valid = 1'b1; req_write = 1'b1; req_addr = 48'h18; req_size = 2'd3;
        req_wdata = 64'hFFFFFFFFFFFFFFFF;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid reset req_ready", 64'(req_ready), 64'd1);
        chk("mid reset rsp_data", rsp_data, 64'd0);
        chk("mid reset rsp_err", 64'(rsp_err), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk("mid reset rsp_valid", 64'(rsp_valid), 64'd0);
            @(negedge clk);
        end
`ifdef DMEM_RESET_CLEAR_EN
        prior18 = 64'h0;
`else
        prior18 = 64'h0123456789ABCDEF;
`endif
        do_req(0, 48'h18, 2'd3, 0, 64'h0, prior18, 0, "ld 0x18 after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
